count_threshold_monitor: RTL and testbench

COUNT_THRESHOLD_MONITOR -- requirements
Module: count_threshold_monitor

---
 rtl/count_threshold_monitor.sv | 190 +++++++++++++++++++
 tb/tb_count_threshold_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_threshold_monitor.sv
// Watches a selected up/down counter value and queues wrap and threshold-crossing events
// into a show-ahead FIFO, alongside a registered above-threshold flag and a running peak.
module count_threshold_monitor #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               din,
    input  logic [1:0]               sel,
    input  logic [7:0]               thr,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [11:0]              evt_data,
    output logic [$clog2(DEPTH):0]   evt_level,
    output logic                     above,
    output logic [7:0]               max_val,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    localparam logic [1:0] EvRise   = 2'b00;
    localparam logic [1:0] EvFall   = 2'b01;
    localparam logic [1:0] EvWrapUp = 2'b10;
    localparam logic [1:0] EvWrapDn = 2'b11;

    // ------------------------------------------------------------------
    // Baseline tracking
    // ------------------------------------------------------------------
    logic [7:0] prev_val_q;
    logic [1:0] prev_sel_q;
    logic       sampled_q;
    logic       sel_same;
    logic       base_ok;

    assign sel_same = (sel == prev_sel_q);
    // A valid baseline needs a prior sample taken with the same counter selected.
    assign base_ok  = sampled_q && sel_same;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_val_q <= '0;
            prev_sel_q <= '0;
            sampled_q  <= 1'b0;
        end else begin
            prev_val_q <= din;
            prev_sel_q <= sel;
            sampled_q  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic [7:0] max_code;
    logic       evt_hit;
    logic [1:0] evt_type;

    always_comb begin
        max_code = 8'd255;
        unique case (sel)
            2'b00: max_code = 8'd31;
            2'b01: max_code = 8'd63;
            2'b10: max_code = 8'd127;
            2'b11: max_code = 8'd255;
            default: max_code = 8'd255;
        endcase
    end

    always_comb begin
        evt_hit  = 1'b0;
        evt_type = EvRise;
        if (base_ok) begin
            if (prev_val_q == max_code && din == 8'd0) begin
                evt_hit  = 1'b1;
                evt_type = EvWrapUp;
            end else if (prev_val_q == 8'd0 && din == max_code) begin
                evt_hit  = 1'b1;
                evt_type = EvWrapDn;
            end else if (prev_val_q < thr && din >= thr) begin
                evt_hit  = 1'b1;
                evt_type = EvRise;
            end else if (prev_val_q >= thr && din < thr) begin
                evt_hit  = 1'b1;
                evt_type = EvFall;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;

    assign fifo_full = (level_q == FullLevel);
    assign evt_valid = (level_q != '0);
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign drop      = evt_hit && fifo_full && !pop;
    assign push      = evt_hit && !drop;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {evt_type, sel, din};
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 12'h000;
    assign evt_level = level_q;

    // ------------------------------------------------------------------
    // Status: above flag, peak value, sticky overflow
    // ------------------------------------------------------------------
    logic       above_q;
    logic [7:0] max_q;
    logic [7:0] max_d;
    logic       ovf_q;
    logic       ovf_d;

    always_comb begin
        max_d = max_q;
        if (!sel_same) begin
            max_d = din;
        end else if (din > max_q) begin
            max_d = din;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            above_q <= 1'b0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            above_q <= (din >= thr);
            max_q   <= max_d;
            ovf_q   <= ovf_d;
        end
    end

    assign above    = above_q;
    assign max_val  = max_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_count_threshold_monitor.sv
// Directed bench for count_threshold_monitor: a queue-based event model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_count_threshold_monitor;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW = $clog2(DEPTH);

    logic          clk;
    logic          rst_n;
    logic [7:0]    din;
    logic [1:0]    sel;
    logic [7:0]    thr;
    logic          evt_valid;
    logic          evt_ready;
    logic [11:0]   evt_data;
    logic [AW:0]   evt_level;
    logic          above;
    logic [7:0]    max_val;
    logic          overflow;
    logic          clr_ovf;

    int checks = 0;
    int failures = 0;

    count_threshold_monitor #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .thr       (thr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_level (evt_level),
        .above     (above),
        .max_val   (max_val),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: event queue plus status values, advanced on each clock edge.
    logic [11:0] m_q[$];
    logic [7:0]  m_prev_val;
    logic [1:0]  m_prev_sel;
    logic        m_sampled;
    logic [7:0]  m_max;
    logic        m_above;
    logic        m_ovf;

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] mc;
        logic       ev;
        logic [1:0] ty;
        logic       mpop;
        logic       mdrop;
        if (!rst_n) begin
            m_q.delete();
            m_prev_val = 8'd0;
            m_prev_sel = 2'd0;
            m_sampled  = 1'b0;
            m_max      = 8'd0;
            m_above    = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            mc = 8'((32 << sel) - 1);
            ev = 1'b0;
            ty = 2'd0;
            if (m_sampled && sel == m_prev_sel) begin
                if (m_prev_val == mc && din == 8'd0) begin
                    ev = 1'b1; ty = 2'd2;
                end else if (m_prev_val == 8'd0 && din == mc) begin
                    ev = 1'b1; ty = 2'd3;
                end else if (m_prev_val < thr && din >= thr) begin
                    ev = 1'b1; ty = 2'd0;
                end else if (m_prev_val >= thr && din < thr) begin
                    ev = 1'b1; ty = 2'd1;
                end
            end
            mpop  = (m_q.size() != 0) && evt_ready;
            mdrop = ev && (m_q.size() == DEPTH) && !mpop;
            if (mpop) void'(m_q.pop_front());
            if (ev && !mdrop) m_q.push_back({ty, sel, din});
            if (mdrop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (sel != m_prev_sel || din > m_max) m_max = din;
            m_above    = (din >= thr);
            m_prev_val = din;
            m_prev_sel = sel;
            m_sampled  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_valid", 32'(evt_valid), 32'(m_q.size() != 0));
            chk("cmp_level", 32'(evt_level), 32'(m_q.size()));
            if (m_q.size() != 0) chk("cmp_data", 32'(evt_data), 32'(m_q[0]));
            chk("cmp_above", 32'(above), 32'(m_above));
            chk("cmp_max", 32'(max_val), 32'(m_max));
            chk("cmp_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic [7:0] t,
                         input logic r);
        din = d;
        sel = s;
        thr = t;
        evt_ready = r;
    endtask

    logic [7:0]  pat_din [16] = '{8'd0, 8'd63, 8'd0, 8'd20, 8'd40, 8'd63, 8'd0, 8'd0,
                                  8'd35, 8'd10, 8'd127, 8'd0, 8'd127, 8'd5, 8'd63, 8'd31};
    logic [11:0] drain_exp [3] = '{12'h3C8, 12'h732, 12'h732};

    initial begin
        rst_n = 1'b0;
        clr_ovf = 1'b0;
        drive(8'd0, 2'd0, 8'd0, 1'b0);
        tick();
        tick();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_level", 32'(evt_level), 32'd0);
        chk("rst_data", 32'(evt_data), 32'd0);
        chk("rst_max", 32'(max_val), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Single RISE at threshold 10
        drive(8'd9, 2'd0, 8'd10, 1'b1);
        tick();
        chk("rise_none_yet", 32'(evt_valid), 32'd0);
        drive(8'd10, 2'd0, 8'd10, 1'b1);
        tick();
        chk("rise_valid", 32'(evt_valid), 32'd1);
        chk("rise_data", 32'(evt_data), 32'h00A);
        chk("rise_above", 32'(above), 32'd1);
        tick();
        chk("rise_one_cycle", 32'(evt_valid), 32'd0);

        // WRAP_UP beats FALL
        drive(8'd31, 2'd0, 8'd5, 1'b1);
        tick();
        chk("wrap_pre", 32'(evt_valid), 32'd0);
        drive(8'd0, 2'd0, 8'd5, 1'b1);
        tick();
        chk("wrap_valid", 32'(evt_valid), 32'd1);
        chk("wrap_level", 32'(evt_level), 32'd1);
        chk("wrap_data", 32'(evt_data), 32'h800);
        tick();
        chk("wrap_no_fall", 32'(evt_valid), 32'd0);

        // Overflow with a stalled consumer
        drive(8'd0, 2'd3, 8'd128, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? 8'd200 : 8'd50, 2'd3, 8'd128, 1'b0);
            tick();
            if (i == 0) chk("ovf_head_held", 32'(evt_data), 32'h3C8);
        end
        chk("ovf_level", 32'(evt_level), 32'd4);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(evt_data), 32'h3C8);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
        chk("ovf_head_stable", 32'(evt_data), 32'h3C8);

        // Push and pop together while full
        drive(8'd50, 2'd3, 8'd128, 1'b1);
        tick();
        chk("full_pp_level", 32'(evt_level), 32'd4);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        chk("full_pp_head", 32'(evt_data), 32'h732);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_level", 32'(evt_level), 32'(3 - i));
            chk("drain_head", 32'(evt_data), 32'(drain_exp[i]));
        end
        tick();
        chk("drain_empty", 32'(evt_valid), 32'd0);

        // Select change suppresses the crossing and reloads the peak
        drive(8'd40, 2'd1, 8'd50, 1'b1);
        tick();
        tick();
        drive(8'd100, 2'd2, 8'd50, 1'b1);
        tick();
        chk("selchg_valid", 32'(evt_valid), 32'd0);
        chk("selchg_level", 32'(evt_level), 32'd0);
        chk("selchg_max", 32'(max_val), 32'd100);

        // Reset with queued events
        drive(8'd10, 2'd2, 8'd50, 1'b0);
        tick();
        drive(8'd100, 2'd2, 8'd50, 1'b0);
        tick();
        drive(8'd10, 2'd2, 8'd50, 1'b0);
        tick();
        chk("queued3", 32'(evt_level), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(evt_valid), 32'd0);
        chk("rst_mid_level", 32'(evt_level), 32'd0);
        chk("rst_mid_data", 32'(evt_data), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(8'd31, 2'd0, 8'd5, 1'b1);
        tick();
        chk("post_rst_baseline", 32'(evt_valid), 32'd0);
        drive(8'd0, 2'd0, 8'd5, 1'b1);
        tick();
        chk("post_rst_event", 32'(evt_data), 32'h800);

        // Pattern sweep with an intermittent consumer, checked by the model
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                drive(pat_din[i], (p == 0) ? 2'd1 : 2'd2, 8'd30, (i % 3) != 0);
                clr_ovf = (i == 12);
                tick();
            end
        end
        clr_ovf = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
